seg_scan_display: RTL and testbench

- Parametrised successor to the single-digit hex-to-seven-segment decoder.
- Drives NUM_DIGITS common-anode digits from one shared segment bus by time-multiplexing.
- Holds a shadow copy of the hex value, scans one digit per refresh period, and decodes each nibble to active-low segments.
- Sits between the CPU's output/debug register and the board's seven-segment display pins.

---
 rtl/seg_scan_display.sv | 125 ++++++++++++
 tb/tb_seg_scan_display.sv | 131 +++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// Time-multiplexed hex display driver: scans NUM_DIGITS common-anode digits over one active-low segment bus.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is always shown).
module seg_scan_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    en,
  output logic [6:0]              sevenSeg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [2:0]              digit_idx
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       SEL_LAST = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_reg;
  logic [2:0]              sel_reg;
  logic [4*NUM_DIGITS-1:0] shadow_val_reg;
  logic [NUM_DIGITS-1:0]   shadow_dp_reg;
  logic                    tick;

  // Shadow nibbles and dp bits padded to 8 entries so the 3-bit select indexes cleanly.
  logic [3:0]            nib [8];
  logic [7:0]            dp_ext;
  logic [7:0]            blank;
  logic [NUM_DIGITS-1:0] anode_sel;

  assign tick = (cnt_reg == CNT_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ext
      if (gi < NUM_DIGITS) begin : g_real
        assign nib[gi]    = shadow_val_reg[4*gi +: 4];
        assign dp_ext[gi] = shadow_dp_reg[gi];
      end else begin : g_pad
        assign nib[gi]    = 4'h0;
        assign dp_ext[gi] = 1'b0;
      end
    end
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
      assign anode_sel[gi] = (sel_reg != 3'(gi));
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0] zero;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_blank
      assign zero[gi] = (nib[gi] == 4'h0);
      if (gi == 0) begin : g_d0
        assign blank[gi] = 1'b0;
      end else begin : g_dn
        // Padding nibbles read as zero, so this covers every more-significant digit.
        assign blank[gi] = &zero[7:gi];
      end
    end
  endgenerate
`else
  assign blank = 8'h00;
`endif

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      4'hF: decode = 7'h0E;
      default: decode = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg        <= '0;
      sel_reg        <= 3'd0;
      shadow_val_reg <= '0;
      shadow_dp_reg  <= '0;
      anode          <= '1;
      sevenSeg       <= 7'h7F;
      dp             <= 1'b1;
      digit_idx      <= 3'd0;
    end else begin
      cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
      if (tick) begin
        sel_reg <= (sel_reg == SEL_LAST) ? 3'd0 : sel_reg + 3'd1;
      end
      if (load) begin
        shadow_val_reg <= value;
        shadow_dp_reg  <= dp_mask;
      end
      // Scan keeps running while disabled so re-enabling resumes without a phase jump.
      digit_idx <= sel_reg;
      if (!en) begin
        anode    <= '1;
        sevenSeg <= 7'h7F;
        dp       <= 1'b1;
      end else begin
        anode    <= anode_sel;
        sevenSeg <= blank[sel_reg] ? 7'h7F : decode(nib[sel_reg]);
        dp       <= ~dp_ext[sel_reg];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display (4 digits, refresh of 4 cycles): driver queues expectations, monitor compares.
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0;
  logic        load = 1'b0;
  logic [3:0]  dp_mask = 4'h0;
  logic        en = 1'b1;
  logic [6:0]  seven_seg;
  logic        dp;
  logic [3:0]  anode;
  logic [2:0]  digit_idx;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] idx;
  } exp_t;

  exp_t  exp_q [$];
  string name_q [$];
  int    checks = 0;
  int    errors = 0;
  bit    done = 1'b0;

  logic [3:0] an_tab  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seg_tab [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};

  seg_scan_display #(.NUM_DIGITS(4), .REFRESH_DIV(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .dp_mask(dp_mask),
    .en(en), .sevenSeg(seven_seg), .dp(dp), .anode(anode), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input logic r, input logic ld, input logic e, input logic [15:0] v,
                      input logic [3:0] dm, input logic [3:0] ea, input logic [6:0] es,
                      input logic ed, input logic [2:0] ei, input string nm);
    exp_t x;
    @(negedge clk);
    reset = r; load = ld; en = e; value = v; dp_mask = dm;
    x.an = ea; x.seg = es; x.dp = ed; x.idx = ei;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  // Monitor: every rising edge presents a new registered output word.
  initial begin
    exp_t  x;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (anode !== x.an || seven_seg !== x.seg || dp !== x.dp || digit_idx !== x.idx) begin
          errors++;
          $display("FAIL %s: got an=%h seg=%h dp=%b idx=%0d, want an=%h seg=%h dp=%b idx=%0d",
                   nm, anode, seven_seg, dp, digit_idx, x.an, x.seg, x.dp, x.idx);
        end
      end
    end
  end

  initial begin
    int d;
    logic [6:0] blank_or_zero;
`ifdef LEADING_ZERO_BLANK_EN
    blank_or_zero = 7'h7F;
`else
    blank_or_zero = 7'h40;
`endif
    // Reset held for 3 cycles, then release.
    for (int i = 0; i < 3; i++) step(1, 0, 1, 16'h0, 4'h0, 4'hF, 7'h7F, 1, 0, "reset");
    step(0, 0, 1, 16'h0, 4'h0, 4'hE, 7'h40, 1, 0, "release");
    // Load 12AF with dp on digit 2; digit 0 remains lit until the first tick.
    step(0, 1, 1, 16'h12AF, 4'b0100, 4'hE, 7'h40, 1, 0, "load_edge");
    step(0, 0, 1, 16'h0, 4'h0, 4'hE, 7'h0E, 1, 0, "load_lat");
    step(0, 0, 1, 16'h0, 4'h0, 4'hE, 7'h0E, 1, 0, "load_tick");
    for (int i = 0; i < 20; i++) begin
      d = (1 + i / 4) % 4;
      step(0, 0, 1, 16'h0, 4'h0, an_tab[d], seg_tab[d], (d == 2) ? 1'b0 : 1'b1, 3'(d), "scan");
    end
    // Digit 2 lit; load zeros exactly on the tick cycle.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 16'h0, 4'h0, 4'hB, 7'h24, 0, 2, "pre_tick");
    step(0, 1, 1, 16'h0000, 4'h0, 4'hB, 7'h24, 0, 2, "load_on_tick");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0, 4'h0, 4'h7, 7'h40, 1, 3, "after_tick");
    // Reload and blank for 6 cycles; the scan advances underneath.
    step(0, 1, 1, 16'h12AF, 4'b0100, 4'hE, 7'h40, 1, 0, "reload");
    step(0, 0, 1, 16'h0, 4'h0, 4'hE, 7'h0E, 1, 0, "reload_lat");
    step(0, 0, 0, 16'h0, 4'h0, 4'hF, 7'h7F, 1, 0, "en_off");
    step(0, 0, 0, 16'h0, 4'h0, 4'hF, 7'h7F, 1, 0, "en_off");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 16'h0, 4'h0, 4'hF, 7'h7F, 1, 1, "en_off");
    step(0, 0, 1, 16'h0, 4'h0, 4'hB, 7'h24, 0, 2, "en_on");
    step(0, 0, 1, 16'h0, 4'h0, 4'hB, 7'h24, 0, 2, "en_on");
    // Mid-scan reset while digit 2 is lit.
    step(1, 0, 1, 16'h0, 4'h0, 4'hF, 7'h7F, 1, 0, "mid_reset");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0, 4'h0, 4'hE, 7'h40, 1, 0, "restart_d0");
    step(0, 0, 1, 16'h0, 4'h0, 4'hD, 7'h40, 1, 1, "restart_d1");
    // Leading-zero handling on value 0050.
    step(0, 1, 1, 16'h0050, 4'h0, 4'hD, 7'h40, 1, 1, "lz_load");
    step(0, 0, 1, 16'h0, 4'h0, 4'hD, 7'h12, 1, 1, "lz_d1");
    step(0, 0, 1, 16'h0, 4'h0, 4'hD, 7'h12, 1, 1, "lz_d1");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0, 4'h0, 4'hB, blank_or_zero, 1, 2, "lz_d2");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0, 4'h0, 4'h7, blank_or_zero, 1, 3, "lz_d3");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0, 4'h0, 4'hE, 7'h40, 1, 0, "lz_d0");
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL timeout: bench did not complete, want completion");
      $fatal(1);
    end
  end

endmodule
